// File: rtl/hs32_rparb_if.sv
// Read-port bundle between decode2, the debug/CSR requester and the regfile read port.
// slave = the arbiter; master = the requesters plus the regfile that drive it.
interface hs32_rparb_if;
    logic        p_valid_i;
    logic [3:0]  p_addr_i;
    logic [31:0] p_data_o;
    logic        p_stall_o;
    logic        d_valid_i;
    logic [3:0]  d_addr_i;
    logic        d_ready_o;
    logic        d_rvalid_o;
    logic [31:0] d_data_o;
    logic [3:0]  rp_addr_o;
    logic [31:0] rp_data_i;

    modport slave (
        input  p_valid_i, p_addr_i, d_valid_i, d_addr_i, rp_data_i,
        output p_data_o, p_stall_o, d_ready_o, d_rvalid_o, d_data_o, rp_addr_o
    );

    modport master (
        output p_valid_i, p_addr_i, d_valid_i, d_addr_i, rp_data_i,
        input  p_data_o, p_stall_o, d_ready_o, d_rvalid_o, d_data_o, rp_addr_o
    );
endinterface

// File: rtl/hs32_rparb.sv
// Regfile read-port arbiter: pipeline owns the port, debug gets idle cycles or a forced steal.
// Grant/address are combinational, debug data returns 1 cycle after accept; debug waits on d_ready_o.
module hs32_rparb #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    hs32_rparb_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_PIPE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STEAL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          d_rvalid_q, d_rvalid_d;
    logic [31:0]   d_data_q, d_data_d;
    logic          grant;
    logic          conflict;

    assign cnt_inc  = cnt_q + CW'(1);
    assign conflict = bus.d_valid_i & bus.p_valid_i;
    // Reset masks the grant so no request is accepted while the block is held.
    assign grant    = ~reset & bus.d_valid_i & ((state_q == S_STEAL) | ~bus.p_valid_i);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        d_rvalid_d = grant;
        d_data_d   = grant ? bus.rp_data_i : d_data_q;
        case (state_q)
            S_PIPE: begin
                if (conflict) begin
                    cnt_d = CW'(1);
                    if (STARVE_MAX == 1) state_d = S_STEAL;
                    else                 state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.d_valid_i || grant) begin
                    state_d = S_PIPE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(STARVE_MAX)) state_d = S_STEAL;
                end
            end
            S_STEAL: begin
                // One stolen cycle only; a follow-on request restarts from zero.
                state_d = S_PIPE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_PIPE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_PIPE;
            cnt_q      <= '0;
            d_rvalid_q <= 1'b0;
            d_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_rvalid_q <= d_rvalid_d;
            d_data_q   <= d_data_d;
        end
    end

    assign bus.d_ready_o  = grant;
    assign bus.rp_addr_o  = grant ? bus.d_addr_i : bus.p_addr_i;
    assign bus.p_data_o   = bus.rp_data_i;
    assign bus.p_stall_o  = (state_q == S_STEAL);
    assign bus.d_rvalid_o = d_rvalid_q;
    assign bus.d_data_o   = d_data_q;
endmodule
